// File: rtl/plan_act_pkg.sv
// Shared types and PLAN segment constants for the activation units.
package plan_act_pkg;

  // Per-sample activation selector, carried down the pipe with its sample.
  typedef enum logic {
    ACT_SIGMOID = 1'b0,
    ACT_TANH    = 1'b1
  } act_mode_e;

  // Magnitudes are carried at a fixed width so the payload type and the
  // segment evaluator do not depend on the unit's DATA_W; unused upper bits
  // are constant zero and fall away in synthesis.
  localparam int MAG_W = 32;

  // Stage-1 payload: folded magnitude plus what S3 needs to unfold it.
  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic             neg;
    act_mode_e        mode;
    logic             valid;
  } stage_t;

  // 1.0 in the fixed-point format.
  function automatic logic [MAG_W-1:0] plan_one(input int frac_w);
    return MAG_W'(1) << frac_w;
  endfunction

  // 5.0: start of the flat (saturated) segment.
  function automatic logic [MAG_W-1:0] plan_sat_th(input int frac_w);
    return MAG_W'(5) << frac_w;
  endfunction

  // 2.375: start of the shallow segment.
  function automatic logic [MAG_W-1:0] plan_hi_th(input int frac_w);
    return MAG_W'(19) << (frac_w - 3);
  endfunction

  // 0.84375: offset of the shallow segment.
  function automatic logic [MAG_W-1:0] plan_hi_off(input int frac_w);
    return MAG_W'(27) << (frac_w - 5);
  endfunction

  // 0.625: offset of the middle segment.
  function automatic logic [MAG_W-1:0] plan_mid_off(input int frac_w);
    return MAG_W'(5) << (frac_w - 3);
  endfunction

  // 0.5: offset of the steep segment around zero.
  function automatic logic [MAG_W-1:0] plan_lo_off(input int frac_w);
    return MAG_W'(1) << (frac_w - 1);
  endfunction

endpackage

// File: rtl/plan_act_pipe_seg_eval.sv
// Combinational PLAN sigmoid on a non-negative magnitude: picks the segment
// and applies its shift-and-add. Result lies in [0.5, 1.0].
module plan_seg_eval
  import plan_act_pkg::*;
#(
  parameter int FRAC_W = 10
) (
  input  logic [MAG_W-1:0] mag_i,
  output logic [FRAC_W:0]  s_o,
  output logic             sat_o
);

  localparam int               S_W     = FRAC_W + 1;
  localparam logic [MAG_W-1:0] ONE     = plan_one(FRAC_W);
  localparam logic [MAG_W-1:0] SAT_TH  = plan_sat_th(FRAC_W);
  localparam logic [MAG_W-1:0] HI_TH   = plan_hi_th(FRAC_W);
  localparam logic [MAG_W-1:0] HI_OFF  = plan_hi_off(FRAC_W);
  localparam logic [MAG_W-1:0] MID_OFF = plan_mid_off(FRAC_W);
  localparam logic [MAG_W-1:0] LO_OFF  = plan_lo_off(FRAC_W);

  // Segment select; each boundary value belongs to the segment above it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    s_o   = '0;
    sat_o = 1'b0;
    if (mag_i >= SAT_TH) begin
      s_o   = S_W'(ONE);
      sat_o = 1'b1;
    end else if (mag_i >= HI_TH) begin
      s_o = S_W'((mag_i >> 5) + HI_OFF);
    end else if (mag_i >= ONE) begin
      s_o = S_W'((mag_i >> 3) + MID_OFF);
    end else begin
      s_o = S_W'((mag_i >> 2) + LO_OFF);
    end
  end

endmodule

// File: rtl/plan_act_pipe.sv
// Three-stage PLAN sigmoid/tanh unit with valid/ready on both sides.
// S1 folds the sign (and doubles for tanh), S2 evaluates the PLAN segment,
// S3 unfolds the sign and maps to the selected function.
module plan_act_pipe
  import plan_act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(1) << FRAC_W;

  logic adv;

  stage_t            s1_d, s1_q;
  logic [FRAC_W:0]   seg_s;
  logic              seg_sat;
  logic [FRAC_W:0]   s2_s_q;
  logic              s2_sat_q, s2_neg_q, s2_valid_q;
  act_mode_e         s2_mode_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic              out_sat_q, out_valid_q;

  // The whole pipe moves as one unless a finished result is being held.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv & ~rst;

  // S1: fold sign into a saturating magnitude; tanh doubles it.
  always_comb begin
    logic [DATA_W-1:0] abs_v;
    logic [DATA_W-1:0] mag_v;
    abs_v = in_data;
    if (in_data[DATA_W-1]) abs_v = (in_data == MIN_NEG) ? MAX_POS : -in_data;
    mag_v = abs_v;
    if (act_mode_e'(in_mode) == ACT_TANH) mag_v = abs_v[DATA_W-2] ? MAX_POS : (abs_v << 1);
    s1_d.mag   = MAG_W'(mag_v);
    s1_d.neg   = in_data[DATA_W-1];
    s1_d.mode  = act_mode_e'(in_mode);
    s1_d.valid = in_valid;
  end

  // S2: PLAN segment evaluation on the folded magnitude.
  plan_seg_eval #(
    .FRAC_W (FRAC_W)
  ) u_seg_eval (
    .mag_i (s1_q.mag),
    .s_o   (seg_s),
    .sat_o (seg_sat)
  );

  // S3: unfold the sign and map sigmoid to tanh where selected.
  always_comb begin
    logic [DATA_W-1:0] s_ext;
    logic [DATA_W-1:0] t_v;
    s_ext = DATA_W'(s2_s_q);
    t_v   = (s_ext << 1) - ONE_D;
    if (s2_mode_q == ACT_TANH) out_data_d = s2_neg_q ? -t_v : t_v;
    else                       out_data_d = s2_neg_q ? (ONE_D - s_ext) : s_ext;
  end

  // Stage-1 register: folded input sample.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every stage samples
    // the previous stage's old value on the same edge.
    if (rst)      s1_q <= '0;
    else if (adv) s1_q <= s1_d;
  end

  // Stage-2 register: segment result plus sign/mode needed by S3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_s_q     <= '0;
      s2_sat_q   <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_mode_q  <= ACT_SIGMOID;
      s2_valid_q <= 1'b0;
    end else if (adv) begin
      s2_s_q     <= seg_s;
      s2_sat_q   <= seg_sat;
      s2_neg_q   <= s1_q.neg;
      s2_mode_q  <= s1_q.mode;
      s2_valid_q <= s1_q.valid;
    end
  end

  // Output register: held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_data_q  <= out_data_d;
      out_sat_q   <= s2_sat_q;
      out_valid_q <= s2_valid_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_plan_act_pipe.sv
// Directed and scoreboard bench for plan_act_pipe (DATA_W=16, FRAC_W=10).
module tb_plan_act_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sat;

  plan_act_pipe #(.DATA_W(16), .FRAC_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int mode;
    int exp_d;
    int exp_s;
  } vec_t;

  typedef struct {
    int d;
    int s;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   out_cnt = 0;
  bit   drv_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference: integer arithmetic for DATA_W=16, FRAC_W=10.
  function automatic exp_t golden(input int x, input int mode);
    exp_t r;
    int a, s, t;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    if (mode == 1) a = (a * 2 > 32767) ? 32767 : a * 2;
    r.s = 0;
    if (a >= 5120) begin s = 1024; r.s = 1; end
    else if (a >= 2432) s = a / 32 + 864;
    else if (a >= 1024) s = a / 8 + 640;
    else s = a / 4 + 512;
    if (mode == 0) r.d = (x < 0) ? 1024 - s : s;
    else begin
      t   = 2 * s - 1024;
      r.d = (x < 0) ? -t : t;
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int x, input int mode, input int ed, input int es);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_data  = 16'(x);
    in_mode  = mode[0];
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else begin
      e.d = ed;
      e.s = es;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_g(input int x, input int mode);
    exp_t g;
    g = golden(x, mode);
    send(x, mode, g.d, g.s);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: ordering against the expectation queue, hold stability
  // under backpressure, and in_ready low while the pipe is stalled.
  logic        held_v = 1'b0;
  logic [15:0] held_d;
  logic        held_s;
  always @(negedge clk) begin
    exp_t e;
    if (rst) held_v = 1'b0;
    else begin
      if (held_v) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'($signed(out_data)), int'($signed(held_d)));
        check("hold_sat", int'(out_sat), int'(held_s));
      end
      if (out_valid && !out_ready) check("in_ready_stalled", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        check("out_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", int'($signed(out_data)), e.d);
          check("out_sat", int'(out_sat), e.s);
        end
        out_cnt++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_s = out_sat;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[8];
    int ov[8];
    int base;

    // Directed vectors {x, mode, expected out_data, expected out_sat}.
    vecs.push_back('{0,      0,  512, 0});
    vecs.push_back('{1024,   0,  768, 0});
    vecs.push_back('{2432,   0,  940, 0});
    vecs.push_back('{-1024,  0,  256, 0});
    vecs.push_back('{6000,   0, 1024, 1});
    vecs.push_back('{-32768, 0,    0, 1});
    vecs.push_back('{5119,   0, 1023, 0});
    vecs.push_back('{5120,   0, 1024, 1});
    vecs.push_back('{2431,   0,  943, 0});
    vecs.push_back('{1023,   0,  767, 0});
    vecs.push_back('{-5120,  0,    0, 1});
    vecs.push_back('{512,    1,  512, 0});
    vecs.push_back('{-512,   1, -512, 0});
    vecs.push_back('{0,      1,    0, 0});
    vecs.push_back('{3000,   1, 1024, 1});
    vecs.push_back('{2560,   1, 1024, 1});
    vecs.push_back('{-32768, 1, -1024, 1});
    vecs.push_back('{-1,     1,    0, 0});

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Latency: result appears on the third edge after acceptance.
    send(0, 0, 512, 0);
    @(negedge clk); check("lat_c1_valid", int'(out_valid), 0);
    @(negedge clk); check("lat_c2_valid", int'(out_valid), 0);
    @(negedge clk); check("lat_c3_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;
    drain();

    // Table vectors streamed back-to-back, modes mixed.
    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i].x, vecs[i].mode, vecs[i].exp_d, vecs[i].exp_s);
    drain();

    // Backpressure: six samples, consumer stalls for cycles 4..8.
    base = out_cnt;
    fork
      begin
        send_g(100, 0);
        send_g(-200, 0);
        send_g(3000, 1);
        send_g(-4000, 0);
        send_g(700, 1);
        send_g(20000, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", out_cnt - base, 6);

    // Bubbles: in_valid 1,0,1,0 shows up on out_valid three cycles later.
    pat = '{1, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      exp_t g;
      in_valid = pat[i][0];
      in_data  = 16'(300 * i - 900);
      in_mode  = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        g = golden(300 * i - 900, 0);
        exp_q.push_back(g);
      end
      ov[i] = int'(out_valid);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 3; i < 8; i++) check($sformatf("bubble_c%0d", i), ov[i], pat[i-3]);
    drain();

    // Reset with three samples in flight.
    send_g(1500, 0);
    send_g(-1500, 1);
    send_g(4000, 0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = out_cnt;
    send(1024, 0, 768, 0);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("midrst_single_out", out_cnt - base, 1);

    // Random scoreboard with idle gaps and random consumer stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            send_g(int'($signed(16'($urandom))), int'($urandom_range(1)));
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
